pll_rst_seq: RTL and testbench

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

---
 rtl/pll_rst_seq.sv | 131 +++++++++++++
 tb/tb_pll_rst_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a synchronized lock that
// stays stable, then releases the downstream reset; retries on timeout or lock loss.
module pll_rst_seq #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int STABLE_CYCLES  = 4096,
   parameter int LOCK_TIMEOUT   = 1000000,
   parameter int CNT_W          = 20
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic [1:0] state,
   output logic [7:0] retry_cnt,
   output logic [7:0] lost_cnt
);

   typedef enum logic [1:0] {
      ST_PLL_RST   = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABLE    = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] L_PLL_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_STB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_sync1;
   logic             r_sync2;
   logic             w_locked_s;
   logic             w_retry_inc;
   logic             w_lost_inc;
   logic             r_pll_rst;
   logic             r_sys_rst;
   logic             r_ready;
   logic [7:0]       r_retry_cnt;
   logic [7:0]       r_lost_cnt;

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= locked;
         r_sync2 <= r_sync1;
      end
   end

   assign w_locked_s = r_sync2;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_retry_inc = 1'b0;
      w_lost_inc  = 1'b0;
      case (r_state)
         ST_PLL_RST: begin
            if (r_cnt == L_PLL_LAST) begin
               w_state_nxt = ST_WAIT_LOCK;
               w_cnt_nxt   = '0;
            end
         end
         ST_WAIT_LOCK: begin
            if (w_locked_s) begin
               w_state_nxt = ST_STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == L_TO_LAST) begin
               w_state_nxt = ST_PLL_RST;
               w_cnt_nxt   = '0;
               w_retry_inc = 1'b1;
            end
         end
         ST_STABLE: begin
            if (!w_locked_s) begin
               w_state_nxt = ST_WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else if (r_cnt == L_STB_LAST) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end
         end
         ST_RUN: begin
            w_cnt_nxt = '0;
            if (!w_locked_s) begin
               w_state_nxt = ST_PLL_RST;
               w_lost_inc  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_PLL_RST;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs decode the next state so they change on the same edge as r_state.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_PLL_RST;
         r_cnt       <= '0;
         r_pll_rst   <= 1'b1;
         r_sys_rst   <= 1'b1;
         r_ready     <= 1'b0;
         r_retry_cnt <= '0;
         r_lost_cnt  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pll_rst <= (w_state_nxt == ST_PLL_RST);
         r_sys_rst <= (w_state_nxt != ST_RUN);
         r_ready   <= (w_state_nxt == ST_RUN);
         if (w_retry_inc && (r_retry_cnt != '1)) r_retry_cnt <= r_retry_cnt + 8'd1;
         if (w_lost_inc && (r_lost_cnt != '1)) r_lost_cnt <= r_lost_cnt + 8'd1;
      end
   end

   assign pll_rst   = r_pll_rst;
   assign sys_rst   = r_sys_rst;
   assign ready     = r_ready;
   assign state     = r_state;
   assign retry_cnt = r_retry_cnt;
   assign lost_cnt  = r_lost_cnt;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed sequences plus randomized lock activity,
// compared every cycle against a phase/duration model of the sequencer.
module tb_pll_rst_seq;

   localparam int P = 4;
   localparam int S = 8;
   localparam int T = 32;

   logic       refclk = 1'b0;
   logic       rst;
   logic       locked;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic [1:0] state;
   logic [7:0] retry_cnt;
   logic [7:0] lost_cnt;

   int total = 0;
   int bad   = 0;

   // Model: lock samples reach the sequencer two edges late; each phase
   // lasts a number of edges given by the parameters.
   bit m_q[$];
   int m_phase;
   int m_el;
   int m_retry;
   int m_lost;

   pll_rst_seq #(
      .PLL_RST_CYCLES(P),
      .STABLE_CYCLES (S),
      .LOCK_TIMEOUT  (T),
      .CNT_W         (6)
   ) dut (
      .refclk   (refclk),
      .rst      (rst),
      .locked   (locked),
      .pll_rst  (pll_rst),
      .sys_rst  (sys_rst),
      .ready    (ready),
      .state    (state),
      .retry_cnt(retry_cnt),
      .lost_cnt (lost_cnt)
   );

   always #5 refclk = ~refclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      m_q.push_back(1'b0);
      m_q.push_back(1'b0);
      m_phase = 0;
      m_el    = 0;
      m_retry = 0;
      m_lost  = 0;
   endfunction

   function automatic void go(input int ph);
      m_phase = ph;
      m_el    = 0;
   endfunction

   function automatic void model_step(input bit lk);
      bit ls;
      m_q.push_back(lk);
      ls = m_q.pop_front();
      case (m_phase)
         0: begin
            m_el++;
            if (m_el == P) go(1);
         end
         1: begin
            if (ls) go(2);
            else begin
               m_el++;
               if (m_el == T) begin
                  go(0);
                  if (m_retry < 255) m_retry++;
               end
            end
         end
         2: begin
            if (!ls) go(1);
            else begin
               m_el++;
               if (m_el == S) go(3);
            end
         end
         default: begin
            if (!ls) begin
               go(0);
               if (m_lost < 255) m_lost++;
            end
         end
      endcase
   endfunction

   task automatic check_outputs();
      chk("state",     32'(state),     32'(m_phase));
      chk("pll_rst",   32'(pll_rst),   32'(m_phase == 0));
      chk("sys_rst",   32'(sys_rst),   32'(m_phase != 3));
      chk("ready",     32'(ready),     32'(m_phase == 3));
      chk("retry_cnt", 32'(retry_cnt), 32'(m_retry));
      chk("lost_cnt",  32'(lost_cnt),  32'(m_lost));
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge refclk);
         model_step(locked);
         @(negedge refclk);
         check_outputs();
      end
   endtask

   // Called at a falling edge; asserts rst between edges and checks that the
   // outputs clear before the next rising edge.
   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      chk({tag, "_state"},   32'(state),     32'd0);
      chk({tag, "_pll_rst"}, 32'(pll_rst),   32'd1);
      chk({tag, "_sys_rst"}, 32'(sys_rst),   32'd1);
      chk({tag, "_ready"},   32'(ready),     32'd0);
      chk({tag, "_retry"},   32'(retry_cnt), 32'd0);
      chk({tag, "_lost"},    32'(lost_cnt),  32'd0);
      model_reset();
      @(negedge refclk);
      rst = 1'b0;
   endtask

   initial begin
      rst    = 1'b0;
      locked = 1'b0;
      model_reset();
      repeat (2) @(negedge refclk);
      async_reset("init");

      // Release with lock low: PLL reset for P edges, then waiting for lock.
      cycles(P);
      chk("r026_state",   32'(state),   32'd1);
      chk("r026_pll_rst", 32'(pll_rst), 32'd0);
      chk("r026_sys_rst", 32'(sys_rst), 32'd1);

      locked = 1'b1;
      cycles(3);
      chk("r027_stable", 32'(state), 32'd2);
      cycles(S);
      chk("r027_run",   32'(state), 32'd3);
      chk("r027_ready", 32'(ready), 32'd1);

      locked = 1'b0;
      cycles(3);
      chk("r030_state", 32'(state),    32'd0);
      chk("r030_lost",  32'(lost_cnt), 32'd1);
      chk("r030_prst",  32'(pll_rst),  32'd1);

      cycles(P);
      locked = 1'b1;
      cycles(3 + 5);
      locked = 1'b0;
      cycles(3);
      chk("r028_state", 32'(state),     32'd1);
      chk("r028_retry", 32'(retry_cnt), 32'd0);
      locked = 1'b1;
      cycles(3 + S - 1);
      chk("r028_restable", 32'(state), 32'd2);
      cycles(1);
      chk("r028_run", 32'(state), 32'd3);

      // Lock never returns: timeouts accumulate and saturate.
      locked = 1'b0;
      cycles(3 + P);
      chk("r029_wait", 32'(state), 32'd1);
      cycles(T - 1);
      chk("r029_last_wait", 32'(state), 32'd1);
      cycles(1);
      chk("r029_retry_state", 32'(state),     32'd0);
      chk("r029_retry1",      32'(retry_cnt), 32'd1);
      cycles(P);
      chk("r029_back_wait", 32'(state), 32'd1);
      repeat (299) cycles(T + P);
      chk("r029_sat", 32'(retry_cnt), 32'd255);
      cycles(T + P);
      chk("r029_nowrap", 32'(retry_cnt), 32'd255);

      for (int seg = 0; seg < 600; seg++) begin
         if ($urandom_range(0, 49) == 0) async_reset("rnd");
         locked = 1'($urandom_range(0, 1));
         cycles(int'($urandom_range(1, 40)));
      end

      locked = 1'b1;
      cycles(20);
      chk("r031_pre", 32'(state), 32'd3);
      async_reset("r031");
      cycles(P + 3 + S + 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
